// File: rtl/count_monitor.sv
// count_monitor: watches a free-running 5-bit upstream counter and reports
// anomalies (wrap, threshold arrival, stall, skip) as time-stamped events
// through a 4-entry valid/ready event FIFO.
module count_monitor #(
   parameter logic [4:0]  THRESHOLD    = 5'd20,
   parameter int unsigned STALL_CYCLES = 8
) (
   input  logic        clock,
   input  logic        reset,
   input  logic [4:0]  count,
   output logic        ev_valid,
   input  logic        ev_ready,
   output logic [14:0] ev_data,
   output logic [2:0]  ev_level,
   output logic        overflow,
   output logic [7:0]  wrap_count
);

   typedef enum logic [1:0] {
      EV_WRAP   = 2'd0,
      EV_THRESH = 2'd1,
      EV_STALL  = 2'd2,
      EV_SKIP   = 2'd3
   } ev_code_t;

   localparam int unsigned DEPTH       = 4;
   localparam logic [7:0]  STALL_LIMIT = 8'(STALL_CYCLES);
   localparam logic [2:0]  LEVEL_FULL  = 3'(DEPTH);

   logic [4:0]  prev;
   logic        primed;
   logic [7:0]  stamp;
   logic [7:0]  stall_cnt;

   logic [14:0] fifo_mem [DEPTH];
   logic [1:0]  wr_ptr;
   logic [1:0]  rd_ptr;
   logic [2:0]  level;

   logic [4:0]  prev_inc;
   logic        is_wrap;
   logic        is_skip;
   logic        is_thresh;
   logic        is_stall;
   logic        ev_det;
   ev_code_t    ev_code;
   logic [14:0] ev_word;
   logic        pop;
   logic        fifo_full;
   logic        push_ok;

   // Raw anomaly conditions against the previous sample; nothing fires until primed.
   always_comb begin
      prev_inc  = prev + 5'd1;
      is_wrap   = primed && (prev == 5'd31) && (count == 5'd0);
      is_skip   = primed && (count != prev) && (count != prev_inc) && !is_wrap;
      is_thresh = primed && (count == THRESHOLD) && (prev != THRESHOLD);
      // The counter saturates at STALL_LIMIT, so this matches only once per hold.
      is_stall  = primed && (count == prev) && (stall_cnt == STALL_LIMIT - 8'd1);
   end

   // Pick a single event per cycle, highest priority first, and form the FIFO word.
   always_comb begin
      ev_det  = 1'b1;
      ev_code = EV_WRAP;
      if (is_skip) begin
         ev_code = EV_SKIP;
      end else if (is_wrap) begin
         ev_code = EV_WRAP;
      end else if (is_thresh) begin
         ev_code = EV_THRESH;
      end else if (is_stall) begin
         ev_code = EV_STALL;
      end else begin
         ev_det = 1'b0;
      end
      ev_word = {ev_code, count, stamp};
   end

   // FIFO handshake; a full FIFO still accepts a push when the head leaves this cycle.
   always_comb begin
      pop       = (level != 3'd0) && ev_ready;
      fifo_full = (level == LEVEL_FULL);
      push_ok   = ev_det && (!fifo_full || pop);
   end

   assign ev_valid = (level != 3'd0);
   assign ev_level = level;
   assign ev_data  = fifo_mem[rd_ptr];

   // Sample tracking: previous count, priming flag, time stamp and stall run length.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         prev      <= '0;
         primed    <= 1'b0;
         stamp     <= '0;
         stall_cnt <= '0;
      end else begin
         prev   <= count;
         primed <= 1'b1;
         stamp  <= stamp + 8'd1;
         if (!primed || (count != prev)) begin
            stall_cnt <= '0;
         end else if (stall_cnt != STALL_LIMIT) begin
            stall_cnt <= stall_cnt + 8'd1;
         end
      end
   end

   // Event FIFO storage, pointers, occupancy and sticky overflow.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         for (int unsigned i = 0; i < DEPTH; i++) begin
            fifo_mem[i] <= '0;
         end
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         level    <= '0;
         overflow <= 1'b0;
      end else begin
         if (push_ok) begin
            fifo_mem[wr_ptr] <= ev_word;
            wr_ptr           <= wr_ptr + 2'd1;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + 2'd1;
         end
         case ({push_ok, pop})
            2'b10:   level <= level + 3'd1;
            2'b01:   level <= level - 3'd1;
            default: level <= level;
         endcase
         if (ev_det && !push_ok) begin
            overflow <= 1'b1;
         end
      end
   end

   // Saturating tally of WRAP detections, counted whether or not the event was queued.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         wrap_count <= '0;
      end else if ((ev_code == EV_WRAP) && ev_det && (wrap_count != 8'hFF)) begin
         wrap_count <= wrap_count + 8'd1;
      end
   end

endmodule

// File: tb/tb_count_monitor.sv
// Scoreboard bench for count_monitor: directed count sequences push expected
// events; a negedge monitor pops and compares on every accepted transfer.
module tb_count_monitor;

   localparam int NONE = -1;
   localparam int WRAP = 0;
   localparam int THR  = 1;
   localparam int STL  = 2;
   localparam int SKP  = 3;

   logic        clock;
   logic        reset;
   logic [4:0]  count;
   logic        ev_valid;
   logic        ev_ready;
   logic [14:0] ev_data;
   logic [2:0]  ev_level;
   logic        overflow;
   logic [7:0]  wrap_count;

   int checks   = 0;
   int failures = 0;

   logic [14:0] sb_q[$];
   logic [7:0]  cyc;

   count_monitor #(
      .THRESHOLD    (5'd20),
      .STALL_CYCLES (8)
   ) dut (
      .clock      (clock),
      .reset      (reset),
      .count      (count),
      .ev_valid   (ev_valid),
      .ev_ready   (ev_ready),
      .ev_data    (ev_data),
      .ev_level   (ev_level),
      .overflow   (overflow),
      .wrap_count (wrap_count)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Cycles since reset release; equals the stamp of the cycle being driven.
   always @(posedge clock or negedge reset) begin
      if (!reset) cyc <= 8'd0;
      else        cyc <= cyc + 8'd1;
   end

   // Monitor: every accepted transfer must match the oldest expected event.
   always @(negedge clock) begin
      if (reset && ev_valid && ev_ready) begin
         checks++;
         if (sb_q.size() == 0) begin
            failures++;
            $display("FAIL event_pop unexpected got=%h exp=none", ev_data);
         end else begin
            logic [14:0] exp_ev;
            exp_ev = sb_q.pop_front();
            if (ev_data !== exp_ev) begin
               failures++;
               $display("FAIL event_pop got=%h exp=%h", ev_data, exp_ev);
            end
         end
      end
   end

   task automatic check(input string name, input int actual, input int expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("FAIL %s got=%0d exp=%0d", name, actual, expected);
      end
   endtask

   // Drive one sample; code is the event expected in this cycle, keep=0 if it will be dropped.
   task automatic drive(input logic [4:0] c, input int code, input bit keep = 1'b1);
      logic [1:0] cd;
      cd    = 2'(code);
      count = c;
      if (code != NONE && keep) sb_q.push_back({cd, c, cyc});
      @(posedge clock);
      #1;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      reset    = 1'b0;
      count    = 5'd0;
      ev_ready = 1'b1;
      repeat (3) @(posedge clock);
      #1;
      check("rst_valid", int'(ev_valid), 0);
      check("rst_data", int'(ev_data), 0);
      check("rst_level", int'(ev_level), 0);
      check("rst_overflow", int'(overflow), 0);
      check("rst_wrap_count", int'(wrap_count), 0);
      reset = 1'b1;

      // Full ramp 0..31 then wrap to 0: THRESH at 20, WRAP at 0.
      drive(5'd0, NONE);
      for (int i = 1; i < 32; i++) drive(5'(i), (i == 20) ? THR : NONE);
      drive(5'd0, WRAP);
      check("wrap_count_1", int'(wrap_count), 1);

      // Skips: jump, restart to 0, and skip landing on the threshold.
      for (int i = 1; i <= 5; i++) drive(5'(i), NONE);
      drive(5'd9, SKP);
      drive(5'd10, NONE);
      drive(5'd0, SKP);
      drive(5'd1, NONE);
      drive(5'd20, SKP);
      drive(5'd21, NONE);

      // Stall: 12 samples at 7 (STALL on 8th unchanged), then change and hold again.
      drive(5'd7, SKP);
      for (int i = 1; i <= 11; i++) drive(5'd7, (i == 8) ? STL : NONE);
      drive(5'd8, NONE);
      for (int i = 1; i <= 8; i++) drive(5'd8, (i == 8) ? STL : NONE);
      drive(5'd9, NONE);
      check("wrap_count_after_stall", int'(wrap_count), 1);

      // Overflow: six events with consumer stalled, last two dropped.
      ev_ready = 1'b0;
      drive(5'd12, SKP);
      drive(5'd13, NONE);
      drive(5'd15, SKP);
      drive(5'd17, SKP);
      drive(5'd19, SKP);
      drive(5'd25, SKP, 1'b0);
      drive(5'd27, SKP, 1'b0);
      check("full_level", int'(ev_level), 4);
      check("full_overflow", int'(overflow), 1);
      check("full_valid", int'(ev_valid), 1);
      check("full_head_data", int'(ev_data), int'(sb_q[0]));
      ev_ready = 1'b1;
      for (int i = 0; i < 5; i++) drive(5'd27, NONE);
      check("drained_valid", int'(ev_valid), 0);
      check("drained_level", int'(ev_level), 0);

      // Asynchronous reset with three events queued.
      ev_ready = 1'b0;
      drive(5'd28, NONE);
      drive(5'd30, SKP);
      drive(5'd1, SKP);
      drive(5'd5, SKP);
      check("pre_reset_level", int'(ev_level), 3);
      #2;
      reset = 1'b0;
      sb_q.delete();
      #1;
      check("async_rst_valid", int'(ev_valid), 0);
      check("async_rst_level", int'(ev_level), 0);
      check("async_rst_overflow", int'(overflow), 0);
      check("async_rst_data", int'(ev_data), 0);
      check("async_rst_wrap_count", int'(wrap_count), 0);
      count    = 5'd20;
      ev_ready = 1'b1;
      @(posedge clock);
      #1;
      reset = 1'b1;
      drive(5'd20, NONE);
      drive(5'd21, NONE);
      check("prime_no_event_level", int'(ev_level), 0);

      // Full FIFO with simultaneous push and pop.
      ev_ready = 1'b0;
      drive(5'd23, SKP);
      drive(5'd25, SKP);
      drive(5'd27, SKP);
      drive(5'd29, SKP);
      check("full2_level", int'(ev_level), 4);
      check("full2_overflow", int'(overflow), 0);
      ev_ready = 1'b1;
      drive(5'd31, SKP);
      check("pushpop_level", int'(ev_level), 4);
      check("pushpop_overflow", int'(overflow), 0);
      for (int i = 0; i < 4; i++) drive(5'd31, NONE);
      drive(5'd0, WRAP);
      check("wrap_count_post_reset", int'(wrap_count), 1);

      // Wrap counter saturation (stamps also roll over 255->0 here).
      for (int i = 0; i < 253; i++) begin
         drive(5'd31, SKP);
         drive(5'd0, WRAP);
      end
      check("wrap_count_254", int'(wrap_count), 254);
      for (int i = 0; i < 2; i++) begin
         drive(5'd31, SKP);
         drive(5'd0, WRAP);
      end
      check("wrap_count_sat", int'(wrap_count), 255);
      check("sat_overflow", int'(overflow), 0);

      drive(5'd1, NONE);
      drive(5'd2, NONE);
      check("final_level", int'(ev_level), 0);
      check("final_sb_empty", sb_q.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
